// File: rtl/alu_activity_monitor.sv
// Switching-activity monitor for the 16-bit ALU result/flags: counts bit toggles
// between accepted samples and reports raw and weighted sums once per window.
module alu_activity_monitor #(
  parameter int WINDOW = 256,
  parameter int ACC_W  = 24,
  parameter int W_DATA = 4,
  parameter int W_FLAG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [15:0]      in_z,
  input  logic [4:0]       in_flags,
  output logic             est_valid,
  output logic [ACC_W-1:0] est_toggles,
  output logic [ACC_W-1:0] est_energy,
  output logic             est_saturated,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, ACCUM = 2'd2} state_t;
  localparam int CNT_W = $clog2(WINDOW + 1);

  state_t           state_q, state_d;
  logic [15:0]      z_prev_q, z_prev_d;
  logic [4:0]       f_prev_q, f_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_last_q, s1_last_d;
  logic [4:0]       s1_d_tog_q, s1_d_tog_d;
  logic [2:0]       s1_f_tog_q, s1_f_tog_d;
  logic [ACC_W-1:0] acc_tog_q, acc_tog_d;
  logic [ACC_W-1:0] acc_en_q, acc_en_d;
  logic             sticky_q, sticky_d;
  logic             est_valid_q, est_valid_d;
  logic [ACC_W-1:0] est_tog_q, est_tog_d;
  logic [ACC_W-1:0] est_en_q, est_en_d;
  logic             est_sat_q, est_sat_d;

  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      en_add32;
  logic [ACC_W:0]   tog_sum, en_sum;
  logic [ACC_W-1:0] tog_new, en_new;
  logic             tog_sat, en_sat;

  always_comb begin
    accept      = in_valid & enable;
    cnt_inc     = cnt_q + CNT_W'(1);
    state_d     = state_q;
    z_prev_d    = z_prev_q;
    f_prev_d    = f_prev_q;
    cnt_d       = cnt_q;
    s1_valid_d  = 1'b0;
    s1_last_d   = 1'b0;
    s1_d_tog_d  = s1_d_tog_q;
    s1_f_tog_d  = s1_f_tog_q;
    acc_tog_d   = acc_tog_q;
    acc_en_d    = acc_en_q;
    sticky_d    = sticky_q;
    est_valid_d = 1'b0;
    est_tog_d   = est_tog_q;
    est_en_d    = est_en_q;
    est_sat_d   = est_sat_q;

    // Stage 2: saturating accumulation of the sample held in stage 1.
    en_add32 = 32'(s1_d_tog_q) * 32'(W_DATA) + 32'(s1_f_tog_q) * 32'(W_FLAG);
    tog_sum  = {1'b0, acc_tog_q} + (ACC_W+1)'(s1_d_tog_q) + (ACC_W+1)'(s1_f_tog_q);
    en_sum   = {1'b0, acc_en_q} + (ACC_W+1)'(en_add32);
    tog_sat  = tog_sum[ACC_W];
    en_sat   = en_sum[ACC_W];
    tog_new  = tog_sat ? '1 : tog_sum[ACC_W-1:0];
    en_new   = en_sat ? '1 : en_sum[ACC_W-1:0];

    if (s1_valid_q) begin
      if (s1_last_q) begin
        est_valid_d = 1'b1;
        est_tog_d   = tog_new;
        est_en_d    = en_new;
        est_sat_d   = sticky_q | tog_sat | en_sat;
        acc_tog_d   = '0;
        acc_en_d    = '0;
        sticky_d    = 1'b0;
      end else begin
        acc_tog_d = tog_new;
        acc_en_d  = en_new;
        sticky_d  = sticky_q | tog_sat | en_sat;
      end
    end

    // Stage 1 and control.
    case (state_q)
      IDLE: if (enable) state_d = PRIME;
      PRIME: begin
        if (accept) begin
          z_prev_d = in_z;
          f_prev_d = in_flags;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          s1_valid_d = 1'b1;
          s1_d_tog_d = 5'($countones(in_z ^ z_prev_q));
          s1_f_tog_d = 3'($countones(in_flags ^ f_prev_q));
          s1_last_d  = (cnt_inc == CNT_W'(WINDOW));
          cnt_d      = s1_last_d ? '0 : cnt_inc;
          z_prev_d   = in_z;
          f_prev_d   = in_flags;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable aborts everything except the last reported estimate.
    if (!enable) begin
      state_d     = IDLE;
      z_prev_d    = '0;
      f_prev_d    = '0;
      cnt_d       = '0;
      s1_valid_d  = 1'b0;
      s1_last_d   = 1'b0;
      s1_d_tog_d  = '0;
      s1_f_tog_d  = '0;
      acc_tog_d   = '0;
      acc_en_d    = '0;
      sticky_d    = 1'b0;
      est_valid_d = 1'b0;
      est_tog_d   = est_tog_q;
      est_en_d    = est_en_q;
      est_sat_d   = est_sat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      z_prev_q    <= '0;
      f_prev_q    <= '0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_d_tog_q  <= '0;
      s1_f_tog_q  <= '0;
      acc_tog_q   <= '0;
      acc_en_q    <= '0;
      sticky_q    <= 1'b0;
      est_valid_q <= 1'b0;
      est_tog_q   <= '0;
      est_en_q    <= '0;
      est_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_prev_q    <= z_prev_d;
      f_prev_q    <= f_prev_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_d_tog_q  <= s1_d_tog_d;
      s1_f_tog_q  <= s1_f_tog_d;
      acc_tog_q   <= acc_tog_d;
      acc_en_q    <= acc_en_d;
      sticky_q    <= sticky_d;
      est_valid_q <= est_valid_d;
      est_tog_q   <= est_tog_d;
      est_en_q    <= est_en_d;
      est_sat_q   <= est_sat_d;
    end
  end

  assign est_valid     = est_valid_q;
  assign est_toggles   = est_tog_q;
  assign est_energy    = est_en_q;
  assign est_saturated = est_sat_q;
  assign busy          = (state_q == PRIME) || (state_q == ACCUM);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_activity_monitor.sv
// Directed bench for alu_activity_monitor: WINDOW=4 instance with a scoreboard,
// plus an ACC_W=8 instance on the same stimulus for the saturation cases.
module tb_alu_activity_monitor;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        in_valid;
  logic [15:0] in_z;
  logic [4:0]  in_flags;

  logic        est_valid, est_saturated, busy;
  logic [23:0] est_toggles, est_energy;
  logic [1:0]  dbg_state;

  logic        est_valid8, est_saturated8, busy8;
  logic [7:0]  est_toggles8, est_energy8;
  logic [1:0]  dbg_state8;

  int n_chk  = 0;
  int n_pass = 0;
  int est_cnt = 0;
  logic [48:0] exp_q[$];

  alu_activity_monitor #(.WINDOW(4), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_z(in_z),
    .in_flags(in_flags), .est_valid(est_valid), .est_toggles(est_toggles),
    .est_energy(est_energy), .est_saturated(est_saturated), .busy(busy),
    .dbg_state(dbg_state)
  );

  alu_activity_monitor #(.WINDOW(4), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_z(in_z),
    .in_flags(in_flags), .est_valid(est_valid8), .est_toggles(est_toggles8),
    .est_energy(est_energy8), .est_saturated(est_saturated8), .busy(busy8),
    .dbg_state(dbg_state8)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: every est_valid pulse of the 24-bit instance must match the queue head.
  always @(negedge clk) begin
    if (est_valid) begin
      est_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_est", 32'(est_valid), 32'd0);
      end else begin
        logic [48:0] e;
        e = exp_q.pop_front();
        check("sb_toggles", 32'(est_toggles), 32'(e[47:24]));
        check("sb_energy", 32'(est_energy), 32'(e[23:0]));
        check("sb_sat", 32'(est_saturated), 32'(e[48]));
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] z, input logic [4:0] f);
    in_valid = 1'b1;
    in_z     = z;
    in_flags = f;
    step();
    in_valid = 1'b0;
  endtask

  task automatic reprime();
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
  endtask

  // Prime + four data samples toggling all 16 bits; ends in the est_valid cycle.
  task automatic run_seq2(input string tag);
    send(16'h0000, 5'd0);
    send(16'hFFFF, 5'd0);
    send(16'h0000, 5'd0);
    send(16'hFFFF, 5'd0);
    send(16'h0000, 5'd0);
    check({tag, "_early"}, 32'(est_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(est_valid), 32'd1);
    check({tag, "_toggles"}, 32'(est_toggles), 32'd64);
  endtask

  initial begin
    int base;
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_z = '0; in_flags = '0;

    // 1. Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      enable   = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_z     = 16'($urandom_range(0, 65535));
      in_flags = 5'($urandom_range(0, 31));
      step();
    end
    check("rst_est_valid", 32'(est_valid), 32'd0);
    check("rst_toggles", 32'(est_toggles), 32'd0);
    check("rst_energy", 32'(est_energy), 32'd0);
    check("rst_sat", 32'(est_saturated), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0; enable = 1'b1; in_valid = 1'b0; in_z = '0; in_flags = '0;
    step();
    check("busy_after_enable", 32'(busy), 32'd1);

    // 2. Data toggles
    exp_q.push_back({1'b0, 24'd64, 24'd256});
    run_seq2("s2");
    check("s2_energy", 32'(est_energy), 32'd256);
    check("s2_sat", 32'(est_saturated), 32'd0);
    step();
    check("s2_pulse_end", 32'(est_valid), 32'd0);

    // 3. Flag toggles with in_valid gaps
    reprime();
    exp_q.push_back({1'b0, 24'd20, 24'd20});
    for (int i = 0; i < 5; i++) begin
      send(16'h1234, (i % 2 == 0) ? 5'b00000 : 5'b11111);
      if (i < 4) repeat ($urandom_range(1, 3)) step();
    end
    check("s3_early", 32'(est_valid), 32'd0);
    step();
    check("s3_valid", 32'(est_valid), 32'd1);
    check("s3_toggles", 32'(est_toggles), 32'd20);
    check("s3_energy", 32'(est_energy), 32'd20);

    // 4. Back-to-back windows
    reprime();
    exp_q.push_back({1'b0, 24'd32, 24'd128});
    exp_q.push_back({1'b0, 24'd32, 24'd128});
    send(16'h0000, 5'd0);
    for (int i = 1; i <= 8; i++) begin
      send((i % 2 == 1) ? 16'h00FF : 16'h0000, 5'd0);
      if (i == 5) check("s4_w1_valid", 32'(est_valid), 32'd1);
      if (i == 6 || i == 7 || i == 8) check("s4_gap_quiet", 32'(est_valid), 32'd0);
    end
    step();
    check("s4_w2_valid", 32'(est_valid), 32'd1);
    check("s4_w2_toggles", 32'(est_toggles), 32'd32);
    check("s4_w2_energy", 32'(est_energy), 32'd128);

    // 5. Abort after two counted samples
    reprime();
    base = est_cnt;
    send(16'h0000, 5'd0);
    send(16'hFFFF, 5'd0);
    send(16'h0000, 5'd0);
    enable = 1'b0;
    repeat (4) step();
    check("s5_no_est", 32'(est_cnt - base), 32'd0);
    check("s5_hold_toggles", 32'(est_toggles), 32'd32);
    check("s5_hold_energy", 32'(est_energy), 32'd128);
    check("s5_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    step();
    exp_q.push_back({1'b0, 24'd64, 24'd256});
    run_seq2("s5");
    check("s5_energy", 32'(est_energy), 32'd256);

    // 6. Reset mid-operation, then saturation on the 8-bit instance
    step();
    rst = 1'b1;
    step();
    check("s6_rst_toggles", 32'(est_toggles), 32'd0);
    check("s6_rst_energy", 32'(est_energy), 32'd0);
    rst = 1'b0; enable = 1'b1;
    step();
    exp_q.push_back({1'b0, 24'd64, 24'd256});
    run_seq2("s6");
    check("s6_a8_valid", 32'(est_valid8), 32'd1);
    check("s6_a8_toggles", 32'(est_toggles8), 32'd64);
    check("s6_a8_energy", 32'(est_energy8), 32'd255);
    check("s6_a8_sat", 32'(est_saturated8), 32'd1);
    exp_q.push_back({1'b0, 24'd0, 24'd0});
    for (int i = 0; i < 4; i++) send(16'h0000, 5'd0);
    step();
    check("s6_clean_valid", 32'(est_valid8), 32'd1);
    check("s6_clean_toggles", 32'(est_toggles8), 32'd0);
    check("s6_clean_energy", 32'(est_energy8), 32'd0);
    check("s6_clean_sat", 32'(est_saturated8), 32'd0);

    repeat (3) step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_activity_monitor.md
Name: alu_activity_monitor

Overview:
- Sits directly downstream of the 16-bit ALU and consumes its result word and flags each cycle.
- Per accepted sample, counts bit toggles against the previous sample: popcount(Z ^ Z_prev) plus popcount(flags ^ flags_prev).
- Accumulates raw toggles and a weighted switching-energy estimate over a fixed window of samples.
- Reports one estimate per window to the power-estimation datapath.

Parameters:
- WINDOW, 256, samples per reporting window; must be >= 2.
- ACC_W, 24, accumulator and output width.
- W_DATA, 4, energy weight per data-bit toggle.
- W_FLAG, 1, energy weight per flag-bit toggle.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  monitor enable; low aborts the window and returns to IDLE.
- in_valid  in  1  sample strobe; a sample is accepted in any cycle with in_valid=1 and enable=1.
- in_z  in  16  ALU result word Z.
- in_flags  in  5  {Sign, Carry, Zero, Parity, Overflow}, bit 4 = Sign.
- est_valid  out  1  one-cycle pulse; est_* outputs are new this cycle.
- est_toggles  out  ACC_W  total toggles in the window (data + flag).
- est_energy  out  ACC_W  sum over the window of data_toggles*W_DATA + flag_toggles*W_FLAG.
- est_saturated  out  1  the window's toggle or energy sum clamped.
- busy  out  1  state is PRIME or ACCUM.

Behaviour:
- Reset values: all outputs 0; prev registers 0; counters 0; pipeline valids 0; state IDLE.
- States and transitions:
  - IDLE -> PRIME when enable=1.
  - PRIME: the first accepted sample only loads Z_prev/flags_prev. It contributes nothing and is not counted. Then -> ACCUM.
  - ACCUM: each accepted sample computes its toggles against prev, then updates prev. sample_cnt increments, running 1..WINDOW.
  - Any state -> IDLE when enable=0, which takes effect at that edge.
- Pipeline timing, for a sample accepted in cycle N:
  - Stage 1, edge ending N: registers d_tog (0..16) and f_tog (0..5), plus a last tag (sample_cnt == WINDOW).
  - Stage 2, edge ending N+1: adds d_tog+f_tog to acc_tog and d_tog*W_DATA + f_tog*W_FLAG to acc_en.
- Window close: when stage 2 holds a last-tagged sample:
  - est_toggles/est_energy take the final sums and est_saturated takes the window's sticky flag.
  - est_valid=1 in cycle N+2, so latency from the last sample's acceptance is 2 cycles.
  - acc_tog, acc_en and the sticky flag clear at that same edge.
  - sample_cnt wraps to 0 when the last sample is accepted.
  - Prev registers are kept, so the next window needs no re-prime.
  - Back-to-back windows have no dead cycles.
- in_valid gaps: cycles without acceptance change nothing and do not advance the pipeline contribution.
- Saturation: each accumulator clamps independently at 2^ACC_W-1. Either clamp sets the sticky flag for the current window.
- Abort (enable=0 mid-window):
  - Discards the partial window, in-flight pipeline entries, counters and prev registers.
  - No est_valid is produced.
  - est_* values hold their last reported values.
  - Re-enable re-primes.
- Reset mid-operation: identical to the reset values, including est_* cleared to 0.
- est_* outputs hold between est_valid pulses.
- Arithmetic: unsigned throughout; per-sample energy is at most 16*W_DATA + 5*W_FLAG.

Test Plan:
All scenarios use WINDOW=4 and default weights unless stated.
1. Reset: assert rst for 2 cycles with random inputs -> all outputs 0, busy=0; then enable=1 -> busy=1 next cycle.
2. Data toggles: flags=0; Z = 0x0000 (prime), 0xFFFF, 0x0000, 0xFFFF, 0x0000 on consecutive cycles -> est_valid exactly 2 cycles after the 5th sample; est_toggles=64, est_energy=256, est_saturated=0.
3. Flag toggles with gaps: Z held at 0x1234; flags alternate 5'b00000 / 5'b11111 across 5 samples, with in_valid low 1-3 cycles between samples -> est_toggles=20, est_energy=20, est_valid 2 cycles after the last acceptance.
4. Back-to-back windows: prime + 8 continuous samples alternating 0x0000/0x00FF -> two est_valid pulses 4 cycles apart, each est_toggles=32, est_energy=128; no re-prime between windows.
5. Abort: enable drops after 2 counted samples -> no est_valid; est_* unchanged. Re-enable and apply scenario 2's sequence -> est_toggles=64 (the first sample re-primes).
6. Saturation: ACC_W=8; scenario 2's sequence -> est_toggles=64, est_energy=255, est_saturated=1. The next clean window, all-zero toggles -> est_saturated=0, est_energy=0.
